// File: rtl/tdm_slot_sequencer.sv
// TDM frame aligner: hunts for fsync, locks onto a 4-slot frame and feeds the
// 1x4 demux one registered bit per strobe, dropping lock after repeated sync errors.
module tdm_slot_sequencer #(
  parameter int SLOT_BITS     = 8,
  parameter int SYNC_MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       ser_in,
  input  logic       fsync,
  output logic       dmx_in,
  output logic [1:0] dmx_sel,
  output logic       dmx_valid,
  output logic       frame_done,
  output logic       locked,
  output logic       frame_err
);

  localparam int BW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int MW = (SYNC_MISS_MAX > 0) ? $clog2(SYNC_MISS_MAX + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(SYNC_MISS_MAX);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic [1:0]      slot, slot_n;
  logic [MW-1:0]   miss_cnt, miss_n, miss_inc;
  logic            boundary, sync_err, emit;
  logic            dmx_in_n, dmx_valid_n, frame_done_n, frame_err_n;
  logic [1:0]      dmx_sel_n;

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    slot_n       = slot;
    miss_n       = miss_cnt;
    dmx_in_n     = dmx_in;
    dmx_sel_n    = dmx_sel;
    dmx_valid_n  = 1'b0;
    frame_done_n = 1'b0;
    frame_err_n  = 1'b0;
    emit         = 1'b0;
    boundary     = (slot == 2'd0) && (bit_cnt == '0);
    sync_err     = (fsync != boundary);
    miss_inc     = miss_cnt + 1'b1;

    case (state)
      HUNT: begin
        if (bit_en && fsync) begin
          dmx_in_n    = ser_in;
          dmx_sel_n   = 2'd0;
          dmx_valid_n = 1'b1;
          bit_cnt_n   = BW'(1);
          slot_n      = 2'd0;
          miss_n      = '0;
          state_n     = LOCK;
        end
      end
      LOCK: begin
        if (bit_en) begin
          if (sync_err) begin
            frame_err_n = 1'b1;
            if (miss_inc == MISS_MAX) begin
              state_n   = HUNT;
              bit_cnt_n = '0;
              slot_n    = '0;
              miss_n    = '0;
            end else begin
              // flywheel: keep the counted position, ignore the stray marker
              miss_n = miss_inc;
              emit   = 1'b1;
            end
          end else begin
            if (boundary) miss_n = '0;
            emit = 1'b1;
          end
          if (emit) begin
            dmx_in_n     = ser_in;
            dmx_sel_n    = slot;
            dmx_valid_n  = 1'b1;
            frame_done_n = (slot == 2'd3) && (bit_cnt == BIT_LAST);
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_n = '0;
              slot_n    = slot + 2'd1;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      slot       <= '0;
      miss_cnt   <= '0;
      dmx_in     <= 1'b0;
      dmx_sel    <= '0;
      dmx_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      slot       <= slot_n;
      miss_cnt   <= miss_n;
      dmx_in     <= dmx_in_n;
      dmx_sel    <= dmx_sel_n;
      dmx_valid  <= dmx_valid_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
      locked     <= (state_n == LOCK);
    end
  end

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Randomized scoreboard bench for tdm_slot_sequencer: a frame-position model
// predicts every output event; a negedge monitor pops and compares.
module tb_tdm_slot_sequencer;
  localparam int SB    = 8;
  localparam int MISS  = 2;
  localparam int FLEN  = 4 * SB;
  localparam logic [31:0] PAT = 32'hA53CFF00;

  logic clk = 1'b0, rst = 1'b1, bit_en = 1'b0, ser_in = 1'b0, fsync = 1'b0;
  logic dmx_in, dmx_valid, frame_done, locked, frame_err;
  logic [1:0] dmx_sel;

  tdm_slot_sequencer #(.SLOT_BITS(SB), .SYNC_MISS_MAX(MISS)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in), .fsync(fsync),
    .dmx_in(dmx_in), .dmx_sel(dmx_sel), .dmx_valid(dmx_valid),
    .frame_done(frame_done), .locked(locked), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       d;
    logic [1:0] sel;
    logic       fd;
    logic       err;
    logic       lk;
  } ev_t;

  ev_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  // reference model: frame position as a plain bit index 0..FLEN-1
  bit         m_lk;
  int         m_pos, m_miss;
  logic       m_last_d;
  logic [1:0] m_last_sel;

  function automatic void model_reset();
    m_lk = 0; m_pos = 0; m_miss = 0; m_last_d = 1'b0; m_last_sel = 2'd0;
  endfunction

  function automatic void model_step(logic d, logic fs);
    ev_t e;
    bit  bnd, er;
    if (!m_lk) begin
      if (fs) begin
        e = '{v:1'b1, d:d, sel:2'd0, fd:1'b0, err:1'b0, lk:1'b1};
        sbq.push_back(e);
        m_lk = 1; m_pos = 1; m_miss = 0; m_last_d = d; m_last_sel = 2'd0;
      end
    end else begin
      bnd = (m_pos == 0);
      er  = (fs != bnd);
      if (er) m_miss++;
      else if (bnd) m_miss = 0;
      if (er && m_miss >= MISS) begin
        e = '{v:1'b0, d:m_last_d, sel:m_last_sel, fd:1'b0, err:1'b1, lk:1'b0};
        sbq.push_back(e);
        m_lk = 0; m_pos = 0; m_miss = 0;
      end else begin
        e.v = 1'b1; e.d = d; e.sel = 2'(m_pos / SB);
        e.fd = (m_pos == FLEN - 1); e.err = er; e.lk = 1'b1;
        sbq.push_back(e);
        m_last_d = d; m_last_sel = e.sel;
        m_pos = (m_pos + 1) % FLEN;
      end
    end
  endfunction

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    ev_t got, expv;
    if (dmx_valid || frame_err || frame_done) begin
      got = {dmx_valid, dmx_in, dmx_sel, frame_done, frame_err, locked};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output at %0t: got v,d,sel,fd,err,lk=%b (nothing expected)", $time, got);
      end else begin
        expv = sbq.pop_front();
        if (got !== expv) begin
          errors++;
          $display("FAIL sb_event at %0t: got v,d,sel,fd,err,lk=%b expected %b", $time, got, expv);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bit_en = 1'b0;
      fsync  = 1'($urandom_range(0, 1));
      ser_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fsync = 1'b0;
  endtask

  task automatic strobe(input logic d, input logic fs, input int gap);
    ser_in = d; fsync = fs; bit_en = 1'b1;
    model_step(d, fs);
    @(posedge clk); #1;
    bit_en = 1'b0; fsync = 1'b0;
    idle(gap);
  endtask

  task automatic frame(input logic [31:0] data, input logic [31:0] mask,
                       input int gap, input int nbits);
    for (int i = 0; i < nbits; i++) strobe(data[31-i], mask[i], gap);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dmx_in"}, int'(dmx_in), 0);
    chk({tag, "_dmx_sel"}, int'(dmx_sel), 0);
    chk({tag, "_dmx_valid"}, int'(dmx_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    logic [31:0] mask;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // acquire after 5 unsynced strobes, then clean frames
    for (int i = 0; i < 5; i++) strobe(1'($urandom_range(0, 1)), 1'b0, 0);
    chk("no_lock_before_fsync", int'(locked), 0);
    for (int i = 0; i < 4; i++) frame(PAT, 32'h1, 0, FLEN);

    // single missed sync, then recovery
    frame(PAT, 32'h0, 0, FLEN);
    chk("locked_after_one_miss", int'(locked), 1);
    frame(PAT, 32'h1, 0, FLEN);
    frame(PAT, 32'h0, 0, FLEN);
    frame(PAT, 32'h1, 0, FLEN);

    // misplaced fsync at slot 2 bit 3, then a missing one: lock lost
    frame(PAT, 32'h1 | (32'h1 << 19), 0, FLEN);
    frame(PAT, 32'h0, 0, FLEN);
    chk("locked_after_two_errors", int'(locked), 0);
    frame(PAT, 32'h1, 0, FLEN);
    frame(PAT, 32'h1, 0, FLEN);

    // sparse strobes
    frame(PAT, 32'h1, 2, FLEN);
    frame(PAT, 32'h1, 2, FLEN);

    // reset at slot 1 bit 4
    frame(PAT, 32'h1, 0, 12);
    rst = 1'b1; bit_en = 1'b1; ser_in = 1'b1; fsync = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bit_en = 1'b0;
    model_reset();
    check_all_zero("midreset");
    chk("midreset_queue_empty", sbq.size(), 0);
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 0);
    frame(PAT, 32'h1, 0, FLEN);

    // randomized frames, gaps and sync faults
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       mask = 32'h1;
      else if (r == 7) mask = 32'h0;
      else if (r == 8) mask = 32'h1 | (32'h1 << $urandom_range(1, 31));
      else             mask = 32'h1 << $urandom_range(1, 31);
      frame($urandom, mask, $urandom_range(0, 2), FLEN);
    end

    idle(4);
    chk("queue_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
